// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bus bundle for if_prefetch_queue: instruction SRAM port, redirect input and IF->ID handshake.
// The master modport is taken by the prefetch queue; the slave modport by the surrounding pipeline/SRAM.
interface if_prefetch_queue_if #(
    parameter int DEPTH = 4
) ();
    logic                     inst_sram_en;
    logic [31:0]              inst_sram_addr;
    logic [31:0]              inst_sram_rdata;
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     id_allowin;
    logic                     if_to_id_valid;
    logic [31:0]              if_to_id_pc;
    logic [31:0]              if_to_id_inst;
    logic [$clog2(DEPTH):0]   ifq_count;

    modport master (
        output inst_sram_en,
        output inst_sram_addr,
        input  inst_sram_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  id_allowin,
        output if_to_id_valid,
        output if_to_id_pc,
        output if_to_id_inst,
        output ifq_count
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_addr,
        output inst_sram_rdata,
        output redirect_valid,
        output redirect_pc,
        output id_allowin,
        input  if_to_id_valid,
        input  if_to_id_pc,
        input  if_to_id_inst,
        input  ifq_count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// DEPTH-entry instruction prefetch queue between a synchronous instruction SRAM and the ID stage.
// Define IFQ_BYPASS_EN to let a response reach ID in its arrival cycle when the queue is empty.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input logic                 clk,
    input logic                 reset,
    if_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetchPc_r;
    logic          inflight_r;
    logic          inflightStale_r;
    logic [31:0]   inflightPc_r;
    logic [63:0]   queueRam_r [DEPTH];
    logic [PW-1:0] rdPtr_r;
    logic [PW-1:0] wrPtr_r;
    logic [CW-1:0] count_r;

    logic          respValid_s;
    logic          bypass_s;
    logic          queueEmpty_s;
    logic [63:0]   headData_s;
    logic          pop_s;
    logic          queuePop_s;
    logic          push_s;
    logic [CW:0]   credit_s;
    logic          issue_s;

    assign respValid_s  = inflight_r && !inflightStale_r;
    assign queueEmpty_s = (count_r == {CW{1'b0}});
    assign headData_s   = queueRam_r[rdPtr_r];

    // Decide whether this cycle's response is forwarded straight to ID
    always_comb begin
        bypass_s = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (queueEmpty_s && respValid_s) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
`else
        bypass_s = 1'b0;
`endif
    end

    // IF->ID head selection: queue head, or the arriving response when bypassed
    always_comb begin
        bus.if_to_id_valid = 1'b0;
        bus.if_to_id_pc    = 32'h0;
        bus.if_to_id_inst  = 32'h0;
        if (bypass_s) begin
            bus.if_to_id_valid = 1'b1;
            bus.if_to_id_pc    = inflightPc_r;
            bus.if_to_id_inst  = bus.inst_sram_rdata;
        end else begin
            bus.if_to_id_valid = !queueEmpty_s;
            bus.if_to_id_pc    = headData_s[63:32];
            bus.if_to_id_inst  = headData_s[31:0];
        end
    end

    assign pop_s      = bus.if_to_id_valid && bus.id_allowin;
    assign queuePop_s = pop_s && !bypass_s;
    // A response consumed through the bypass never occupies a queue slot
    assign push_s     = respValid_s && !bus.redirect_valid && !(bypass_s && bus.id_allowin);

    assign credit_s = {1'b0, count_r}
                    + {{CW{1'b0}}, inflight_r}
                    - {{CW{1'b0}}, pop_s};
    assign issue_s  = (credit_s < DEPTH_W);

    // SRAM request: redirect target wins, otherwise sequential issue while credit remains
    always_comb begin
        bus.inst_sram_en   = 1'b0;
        bus.inst_sram_addr = fetchPc_r;
        if (reset) begin
            bus.inst_sram_en   = 1'b0;
            bus.inst_sram_addr = fetchPc_r;
        end else if (bus.redirect_valid) begin
            bus.inst_sram_en   = 1'b1;
            bus.inst_sram_addr = bus.redirect_pc;
        end else if (issue_s) begin
            bus.inst_sram_en   = 1'b1;
            bus.inst_sram_addr = fetchPc_r;
        end else begin
            bus.inst_sram_en   = 1'b0;
            bus.inst_sram_addr = fetchPc_r;
        end
    end

    assign bus.ifq_count = count_r;

    // Fetch PC and in-flight request tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc_r       <= RESET_PC;
            inflight_r      <= 1'b0;
            inflightStale_r <= 1'b0;
            inflightPc_r    <= 32'h0;
        end else if (bus.redirect_valid) begin
            fetchPc_r       <= bus.redirect_pc + 32'd4;
            inflight_r      <= 1'b1;
            inflightStale_r <= 1'b0;
            inflightPc_r    <= bus.redirect_pc;
        end else if (issue_s) begin
            fetchPc_r       <= fetchPc_r + 32'd4;
            inflight_r      <= 1'b1;
            inflightStale_r <= 1'b0;
            inflightPc_r    <= fetchPc_r;
        end else begin
            fetchPc_r       <= fetchPc_r;
            inflight_r      <= 1'b0;
            inflightStale_r <= 1'b0;
            inflightPc_r    <= inflightPc_r;
        end
    end

    // Queue pointers and occupancy; a redirect discards everything not popped this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_r <= {PW{1'b0}};
            wrPtr_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (bus.redirect_valid) begin
            rdPtr_r <= wrPtr_r;
            wrPtr_r <= wrPtr_r;
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PW'(1'b1);
            end else begin
                wrPtr_r <= wrPtr_r;
            end
            if (queuePop_s) begin
                rdPtr_r <= rdPtr_r + PW'(1'b1);
            end else begin
                rdPtr_r <= rdPtr_r;
            end
            case ({push_s, queuePop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage: {pc, inst} per entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                queueRam_r[i] <= 64'h0;
            end
        end else if (push_s) begin
            queueRam_r[wrPtr_r] <= {inflightPc_r, bus.inst_sram_rdata};
        end else begin
            queueRam_r[wrPtr_r] <= queueRam_r[wrPtr_r];
        end
    end
endmodule
